// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVS          = 16;
  localparam int SAMPLE_POINT = 9;

  // Rounded clk_hz / (OVS * baud): clock cycles per oversample tick.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (OVS * baud) / 2) / (OVS * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; pointers wrap naturally, count is one bit wider
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling, show-ahead receive FIFO and sticky error flags
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
  localparam logic [3:0]    SC_SAMPLE = 4'(SAMPLE_POINT);

  logic            s1, s2, rs_prev;
  logic            rs;
  logic [PW-1:0]   pcnt;
  logic [3:0]      sc;
  logic            tick;
  logic            smp7, smp8;
  logic            maj;
  logic            sample_now;
  logic            start_det;
  rx_state_t       state;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;

  assign rs         = s2;
  assign tick       = (pcnt == DIV_LAST);
  assign start_det  = (state == IDLE) && rs_prev && !rs;
  assign sample_now = tick && (sc == SC_SAMPLE);
  assign maj        = (smp7 & smp8) | (smp7 & rs) | (smp8 & rs);
  assign pop        = rd && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      s1      <= rx;
      s2      <= s1;
      rs_prev <= s2;
    end
  end

  // Restarting the prescaler on the start edge centres the sc=7..9 window in every bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      sc   <= '0;
    end else if (start_det) begin
      pcnt <= '0;
      sc   <= '0;
    end else if (tick) begin
      pcnt <= '0;
      sc   <= sc + 4'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp7 <= 1'b1;
      smp8 <= 1'b1;
    end else if (tick) begin
      if (sc == SC_SAMPLE - 4'd2) smp7 <= rs;
      if (sc == SC_SAMPLE - 4'd1) smp8 <= rs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push <= 1'b0;
      if (clr_err) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) state <= START;
        end
        START: begin
          if (sample_now) begin
            if (!maj) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shreg   <= {maj, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets the next start edge be caught without losing half a bit.
          if (sample_now) begin
            if (maj) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else begin
      if (clr_err) overrun <= 1'b0;
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (rdata),
    .full  (full),
    .empty (empty)
  );

  assign rx_valid = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo at default parameters
module tb_uart_rx_fifo;

  localparam int BIT = 208;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .rdata     (rdata),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  // Start bit falls 1 time unit after the first edge; frame ends on a posedge with rx high.
  task automatic send_byte(input logic [7:0] b, input int stop_low_bits);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    if (stop_low_bits > 0) begin
      #1 rx = 1'b0;
      repeat (BIT * stop_low_bits) @(posedge clk);
    end
    #1 rx = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    check(tag, rdata, exp);
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", {7'd0, rx_valid}, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ferr", {7'd0, frame_err}, 8'h00);
    check("rst_ovr", {7'd0, overrun}, 8'h00);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Clean 0x55: push lands at E0+2006, so rx_valid is low just before and high just after.
    fork
      send_byte(8'h55, 0);
      begin
        @(posedge clk);
        repeat (2005) @(posedge clk);
        #1 check("t1_valid_pre", {7'd0, rx_valid}, 8'h00);
        repeat (2) @(posedge clk);
        #1 check("t1_valid_post", {7'd0, rx_valid}, 8'h01);
      end
    join
    check("t1_ferr", {7'd0, frame_err}, 8'h00);
    check("t1_ovr", {7'd0, overrun}, 8'h00);
    read_expect("t1_rdata", 8'h55);
    check("t1_empty", {7'd0, rx_valid}, 8'h00);

    // Short low glitch is rejected at the start-bit sample.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("glitch_valid", {7'd0, rx_valid}, 8'h00);
    check("glitch_ferr", {7'd0, frame_err}, 8'h00);
    check("glitch_ovr", {7'd0, overrun}, 8'h00);
    send_byte(8'hC3, 0);
    read_expect("glitch_c3", 8'hC3);

    // Stop bit held low: frame error, nothing pushed, then recovery.
    send_byte(8'hA3, 2);
    #1;
    check("fe_set", {7'd0, frame_err}, 8'h01);
    check("fe_empty", {7'd0, rx_valid}, 8'h00);
    send_byte(8'h3C, 0);
    read_expect("fe_3c", 8'h3C);
    check("fe_sticky", {7'd0, frame_err}, 8'h01);
    pulse_clr();
    check("fe_clr", {7'd0, frame_err}, 8'h00);

    // Nine bytes into an 8-deep FIFO: last one dropped.
    for (int i = 0; i < 9; i++) send_byte(8'(i), 0);
    #1 check("ovr_set", {7'd0, overrun}, 8'h01);
    for (int i = 0; i < 8; i++) read_expect("ovr_data", 8'(i));
    check("ovr_drain", {7'd0, rx_valid}, 8'h00);
    pulse_clr();
    check("ovr_clr", {7'd0, overrun}, 8'h00);

    // Full FIFO with a pop exactly on the push cycle of 0x99.
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 0);
    fork
      send_byte(8'h99, 0);
      begin
        @(posedge clk);
        repeat (2005) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    #1 check("fp_ovr", {7'd0, overrun}, 8'h00);
    for (int i = 1; i < 8; i++) read_expect("fp_data", 8'h10 + 8'(i));
    read_expect("fp_last", 8'h99);
    check("fp_drain", {7'd0, rx_valid}, 8'h00);

    // Reset mid bit 4 of 0xF0 with a stale byte queued.
    send_byte(8'h5A, 0);
    fork
      send_byte(8'hF0, 0);
      begin
        @(posedge clk);
        repeat (BIT * 5 + 104) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mr_valid", {7'd0, rx_valid}, 8'h00);
        check("mr_rdata", rdata, 8'h00);
        check("mr_ferr", {7'd0, frame_err}, 8'h00);
        check("mr_ovr", {7'd0, overrun}, 8'h00);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
      end
    join
    #1 check("mr_no_partial", {7'd0, rx_valid}, 8'h00);
    send_byte(8'h81, 0);
    read_expect("mr_81", 8'h81);
    check("mr_only", {7'd0, rx_valid}, 8'h00);
    check("mr_ferr_end", {7'd0, frame_err}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
